// File: rtl/mpsoc_memory_arbiter.sv
// mpsoc_memory_arbiter: two Avalon-MM requesters share one single-port RAM (32-bit, byte enables).
// Latency: writes complete in the grant cycle; read data returns exactly 1 cycle after acceptance.
// Backpressure: round-robin on conflict, the loser sees waitrequest=1; both ports stall during the zero-fill sweep.
//
// Ports:
//   clk, reset_n                 - single clock, asynchronous active-low reset
//   p0_* / p1_*                  - Avalon-MM slave ports (address, read, write, byteenable, writedata,
//                                  waitrequest, readdata, readdatavalid)
//   mem_*                        - RAM master side (address, chipselect, write, byteenable, writedata,
//                                  readdata, clken)
//   oor_flag, oor_clear          - sticky per-port out-of-range flags and their synchronous clear
//   busy_clearing                - high while the post-reset zero-fill sweep runs
module mpsoc_memory_arbiter #(
  parameter int DEPTH          = 25600,
  parameter int ADDR_W         = 15,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic              clk,
  input  logic              reset_n,

  input  logic [ADDR_W-1:0] p0_address,
  input  logic              p0_read,
  input  logic              p0_write,
  input  logic [3:0]        p0_byteenable,
  input  logic [31:0]       p0_writedata,
  output logic              p0_waitrequest,
  output logic [31:0]       p0_readdata,
  output logic              p0_readdatavalid,

  input  logic [ADDR_W-1:0] p1_address,
  input  logic              p1_read,
  input  logic              p1_write,
  input  logic [3:0]        p1_byteenable,
  input  logic [31:0]       p1_writedata,
  output logic              p1_waitrequest,
  output logic [31:0]       p1_readdata,
  output logic              p1_readdatavalid,

  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_chipselect,
  output logic              mem_write,
  output logic [3:0]        mem_byteenable,
  output logic [31:0]       mem_writedata,
  input  logic [31:0]       mem_readdata,
  output logic              mem_clken,

  output logic [1:0]        oor_flag,
  input  logic              oor_clear,
  output logic              busy_clearing
);

  typedef enum logic {ST_CLEAR, ST_SERVE} state_t;

  // One extra bit so a DEPTH equal to 2**ADDR_W still compares correctly.
  localparam logic [ADDR_W:0]   DEPTH_W   = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam state_t            RST_STATE = CLEAR_ON_RESET ? ST_CLEAR : ST_SERVE;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] clr_cnt;
  logic              rr_ptr;
  logic              rd_pending;
  logic              rd_port;
  logic              rd_oor;

  logic              req0, req1;
  logic              grant;
  logic              winner;
  logic [ADDR_W-1:0] win_address;
  logic              win_read, win_write;
  logic [3:0]        win_byteenable;
  logic [31:0]       win_writedata;
  logic              win_oor;
  logic [1:0]        oor_set;

  // ---------------- arbitration ----------------
  always_comb begin
    req0           = p0_read | p0_write;
    req1           = p1_read | p1_write;
    grant          = (state == ST_SERVE) && (req0 || req1);
    // Contention resolved by rr_ptr; otherwise whoever is requesting.
    winner         = (req0 && req1) ? rr_ptr : req1;
    win_address    = winner ? p1_address    : p0_address;
    win_read       = winner ? p1_read       : p0_read;
    win_write      = winner ? p1_write      : p0_write;
    win_byteenable = winner ? p1_byteenable : p0_byteenable;
    win_writedata  = winner ? p1_writedata  : p0_writedata;
    win_oor        = ({1'b0, win_address} >= DEPTH_W);
    oor_set        = {grant & winner & win_oor, grant & ~winner & win_oor};
  end

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= RST_STATE;
    else          state <= state_nxt;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_nxt = state;
    if (state == ST_CLEAR && clr_cnt == LAST_ADDR) state_nxt = ST_SERVE;
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    mem_address    = '0;
    mem_chipselect = 1'b0;
    mem_write      = 1'b0;
    mem_byteenable = 4'h0;
    mem_writedata  = 32'h0;
    busy_clearing  = 1'b0;
    p0_waitrequest = 1'b0;
    p1_waitrequest = 1'b0;
    case (state)
      ST_CLEAR: begin
        mem_address    = clr_cnt;
        mem_chipselect = 1'b1;
        mem_write      = 1'b1;
        mem_byteenable = 4'hF;
        busy_clearing  = 1'b1;
        p0_waitrequest = 1'b1;
        p1_waitrequest = 1'b1;
      end
      ST_SERVE: begin
        // Only a requesting port that lost arbitration is stalled.
        p0_waitrequest = req0 & winner;
        p1_waitrequest = req1 & ~winner;
        if (grant) begin
          mem_address    = win_address;
          mem_byteenable = win_byteenable;
          mem_writedata  = win_writedata;
          // Out-of-range commands are accepted but never reach the RAM.
          mem_chipselect = ~win_oor;
          mem_write      = win_write & ~win_oor;
        end
      end
      default: ;
    endcase
  end

  // ---------------- datapath registers ----------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      clr_cnt    <= '0;
      rr_ptr     <= 1'b0;
      rd_pending <= 1'b0;
      rd_port    <= 1'b0;
      rd_oor     <= 1'b0;
      oor_flag   <= 2'b00;
    end else begin
      if (state == ST_CLEAR) clr_cnt <= (clr_cnt == LAST_ADDR) ? '0 : clr_cnt + 1'b1;
      if (grant) rr_ptr <= ~winner;
      // Read+write together behaves as a write: no return is scheduled.
      rd_pending <= grant & win_read & ~win_write;
      rd_port    <= winner;
      rd_oor     <= win_oor;
      // A set in the same cycle as oor_clear takes priority.
      oor_flag   <= (oor_clear ? 2'b00 : oor_flag) | oor_set;
    end
  end

  // ---------------- read return routing ----------------
  always_comb begin
    p0_readdatavalid = rd_pending & ~rd_port;
    p1_readdatavalid = rd_pending &  rd_port;
    p0_readdata      = (p0_readdatavalid && !rd_oor) ? mem_readdata : 32'h0;
    p1_readdata      = (p1_readdatavalid && !rd_oor) ? mem_readdata : 32'h0;
    mem_clken        = 1'b1;
  end

endmodule

// File: tb/tb_mpsoc_memory_arbiter.sv
module tb_mpsoc_memory_arbiter;

  localparam int AW = 15;

  logic clk;
  logic reset_n_a, reset_n_b;
  logic preload;

  // Shared requester inputs.
  logic [AW-1:0] p0_address, p1_address;
  logic          p0_read, p0_write, p1_read, p1_write;
  logic [3:0]    p0_byteenable, p1_byteenable;
  logic [31:0]   p0_writedata, p1_writedata;
  logic          oor_clear;

  // Instance A (DEPTH=16) outputs.
  logic          a_p0_waitrequest, a_p0_readdatavalid, a_p1_waitrequest, a_p1_readdatavalid;
  logic [31:0]   a_p0_readdata, a_p1_readdata;
  logic [AW-1:0] a_mem_address;
  logic          a_mem_chipselect, a_mem_write, a_mem_clken, a_busy;
  logic [3:0]    a_mem_byteenable;
  logic [31:0]   a_mem_writedata, a_mem_readdata;
  logic [1:0]    a_oor_flag;

  // Instance B (default DEPTH=25600) outputs.
  logic          b_p0_waitrequest, b_p0_readdatavalid, b_p1_waitrequest, b_p1_readdatavalid;
  logic [31:0]   b_p0_readdata, b_p1_readdata;
  logic [AW-1:0] b_mem_address;
  logic          b_mem_chipselect, b_mem_write, b_mem_clken, b_busy;
  logic [3:0]    b_mem_byteenable;
  logic [31:0]   b_mem_writedata, b_mem_readdata;
  logic [1:0]    b_oor_flag;

  int tests = 0;
  int fails = 0;

  mpsoc_memory_arbiter #(.DEPTH(16), .ADDR_W(AW), .CLEAR_ON_RESET(1'b1)) dut_a (
    .clk(clk), .reset_n(reset_n_a),
    .p0_address(p0_address), .p0_read(p0_read), .p0_write(p0_write),
    .p0_byteenable(p0_byteenable), .p0_writedata(p0_writedata),
    .p0_waitrequest(a_p0_waitrequest), .p0_readdata(a_p0_readdata), .p0_readdatavalid(a_p0_readdatavalid),
    .p1_address(p1_address), .p1_read(p1_read), .p1_write(p1_write),
    .p1_byteenable(p1_byteenable), .p1_writedata(p1_writedata),
    .p1_waitrequest(a_p1_waitrequest), .p1_readdata(a_p1_readdata), .p1_readdatavalid(a_p1_readdatavalid),
    .mem_address(a_mem_address), .mem_chipselect(a_mem_chipselect), .mem_write(a_mem_write),
    .mem_byteenable(a_mem_byteenable), .mem_writedata(a_mem_writedata), .mem_readdata(a_mem_readdata),
    .mem_clken(a_mem_clken), .oor_flag(a_oor_flag), .oor_clear(oor_clear), .busy_clearing(a_busy)
  );

  mpsoc_memory_arbiter #(.DEPTH(25600), .ADDR_W(AW), .CLEAR_ON_RESET(1'b1)) dut_b (
    .clk(clk), .reset_n(reset_n_b),
    .p0_address(p0_address), .p0_read(p0_read), .p0_write(p0_write),
    .p0_byteenable(p0_byteenable), .p0_writedata(p0_writedata),
    .p0_waitrequest(b_p0_waitrequest), .p0_readdata(b_p0_readdata), .p0_readdatavalid(b_p0_readdatavalid),
    .p1_address(p1_address), .p1_read(p1_read), .p1_write(p1_write),
    .p1_byteenable(p1_byteenable), .p1_writedata(p1_writedata),
    .p1_waitrequest(b_p1_waitrequest), .p1_readdata(b_p1_readdata), .p1_readdatavalid(b_p1_readdatavalid),
    .mem_address(b_mem_address), .mem_chipselect(b_mem_chipselect), .mem_write(b_mem_write),
    .mem_byteenable(b_mem_byteenable), .mem_writedata(b_mem_writedata), .mem_readdata(b_mem_readdata),
    .mem_clken(b_mem_clken), .oor_flag(b_oor_flag), .oor_clear(oor_clear), .busy_clearing(b_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM models: 1-cycle read latency, byte-lane writes. Preload puts garbage in so the sweep is visible.
  logic [31:0] mem_a [0:15];
  logic [31:0] mem_b [0:32767];

  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 16; i++) mem_a[i] <= 32'hA5A5A5A5;
    end else if (a_mem_chipselect) begin
      if (a_mem_write) begin
        for (int i = 0; i < 4; i++)
          if (a_mem_byteenable[i]) mem_a[a_mem_address[3:0]][8*i +: 8] <= a_mem_writedata[8*i +: 8];
      end else a_mem_readdata <= mem_a[a_mem_address[3:0]];
    end
  end

  always @(posedge clk) begin
    if (preload) begin
      mem_b[16] <= 32'h5A5A5A5A;
    end else if (b_mem_chipselect) begin
      if (b_mem_write) begin
        for (int i = 0; i < 4; i++)
          if (b_mem_byteenable[i]) mem_b[b_mem_address][8*i +: 8] <= b_mem_writedata[8*i +: 8];
      end else b_mem_readdata <= mem_b[b_mem_address];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    p0_read = 1'b0; p0_write = 1'b0; p1_read = 1'b0; p1_write = 1'b0;
    p0_address = '0; p1_address = '0;
    p0_byteenable = 4'hF; p1_byteenable = 4'hF;
    p0_writedata = 32'h0; p1_writedata = 32'h0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    idle_inputs();
    oor_clear = 1'b0;
    preload   = 1'b1;
    reset_n_a = 1'b0;
    reset_n_b = 1'b0;
    a_mem_readdata = 32'h0;
    b_mem_readdata = 32'h0;
    tick(); tick();
    preload = 1'b0;

    // ---- reset state of instance A ----
    @(negedge clk);
    chk("rst_wait0", 32'(a_p0_waitrequest), 32'd1);
    chk("rst_wait1", 32'(a_p1_waitrequest), 32'd1);
    chk("rst_busy", 32'(a_busy), 32'd1);
    chk("rst_rdv", 32'({a_p0_readdatavalid, a_p1_readdatavalid}), 32'd0);
    chk("rst_rdata", a_p0_readdata | a_p1_readdata, 32'h0);
    chk("rst_oor", 32'(a_oor_flag), 32'd0);
    chk("rst_clken", 32'(a_mem_clken), 32'd1);

    // ---- test 1: zero-fill sweep, DEPTH=16 ----
    tick();
    reset_n_a = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      chk("clr_busy", 32'(a_busy), 32'd1);
      chk("clr_addr", 32'(a_mem_address), 32'(i));
      chk("clr_wr", 32'({a_mem_chipselect, a_mem_write, a_mem_byteenable}), 32'h3F);
      chk("clr_data", a_mem_writedata, 32'h0);
    end
    @(negedge clk);
    chk("clr_done_busy", 32'(a_busy), 32'd0);
    chk("clr_done_wait", 32'(a_p0_waitrequest), 32'd0);

    tick();
    p0_read = 1'b1; p0_address = 15'd5;
    @(negedge clk);
    chk("t1_wait", 32'(a_p0_waitrequest), 32'd0);
    chk("t1_cs", 32'(a_mem_chipselect), 32'd1);
    chk("t1_addr", 32'(a_mem_address), 32'd5);
    tick();
    idle_inputs();
    @(negedge clk);
    chk("t1_rdv0", 32'(a_p0_readdatavalid), 32'd1);
    chk("t1_rdv1", 32'(a_p1_readdatavalid), 32'd0);
    chk("t1_data", a_p0_readdata, 32'h0);

    // ---- test 6: read+write together acts as a write (rr_ptr now 1) ----
    tick();
    p0_read = 1'b1; p0_write = 1'b1; p0_address = 15'd3; p0_writedata = 32'h12345678;
    @(negedge clk);
    chk("t6_cs_wr", 32'({a_mem_chipselect, a_mem_write}), 32'd3);
    chk("t6_addr", 32'(a_mem_address), 32'd3);
    tick();
    idle_inputs();
    @(negedge clk);
    chk("t6_no_rdv", 32'({a_p0_readdatavalid, a_p1_readdatavalid}), 32'd0);
    tick();
    p1_read = 1'b1; p1_address = 15'd3;
    @(negedge clk);
    chk("t6_rd_wait", 32'(a_p1_waitrequest), 32'd0);
    tick();
    idle_inputs();
    @(negedge clk);
    chk("t6_rdv1", 32'(a_p1_readdatavalid), 32'd1);
    chk("t6_rdv0", 32'(a_p0_readdatavalid), 32'd0);
    chk("t6_data", a_p1_readdata, 32'h12345678);

    // ---- setup for test 3: distinct data in words 1 and 2 (rr_ptr ends at 0) ----
    tick();
    p0_write = 1'b1; p0_address = 15'd1; p0_writedata = 32'h11111111;
    tick();
    idle_inputs();
    p1_write = 1'b1; p1_address = 15'd2; p1_writedata = 32'h22222222;
    tick();
    idle_inputs();

    // ---- test 3: both ports hold reads, grants alternate p0,p1,... ----
    p0_read = 1'b1; p0_address = 15'd1;
    p1_read = 1'b1; p1_address = 15'd2;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("t3_wait0", 32'(a_p0_waitrequest), 32'(k % 2 != 0));
      chk("t3_wait1", 32'(a_p1_waitrequest), 32'(k % 2 == 0));
      chk("t3_addr", 32'(a_mem_address), (k % 2 == 0) ? 32'd1 : 32'd2);
      if (k > 0) begin
        chk("t3_rdv0", 32'(a_p0_readdatavalid), 32'((k - 1) % 2 == 0));
        chk("t3_rdv1", 32'(a_p1_readdatavalid), 32'((k - 1) % 2 != 0));
        chk("t3_data", a_p0_readdata | a_p1_readdata,
            ((k - 1) % 2 == 0) ? 32'h11111111 : 32'h22222222);
      end
      tick();
    end
    idle_inputs();
    @(negedge clk);
    chk("t3_last_rdv1", 32'(a_p1_readdatavalid), 32'd1);
    chk("t3_last_rdv0", 32'(a_p0_readdatavalid), 32'd0);
    chk("t3_last_data", a_p1_readdata, 32'h22222222);
    chk("t3_idle_wait", 32'({a_p0_waitrequest, a_p1_waitrequest}), 32'd0);
    chk("t3_idle_cs", 32'(a_mem_chipselect), 32'd0);

    // ---- test 5: reset between grant and return drops the return ----
    tick();
    p0_read = 1'b1; p0_address = 15'd1;
    @(negedge clk);
    chk("t5_wait", 32'(a_p0_waitrequest), 32'd0);
    #1;
    reset_n_a = 1'b0;
    idle_inputs();
    tick();
    chk("t5_rdv_in_rst", 32'(a_p0_readdatavalid), 32'd0);
    tick();
    reset_n_a = 1'b1;
    @(negedge clk);
    chk("t5_rdv_after", 32'(a_p0_readdatavalid), 32'd0);
    chk("t5_wait_after", 32'(a_p0_waitrequest), 32'd1);
    chk("t5_busy_after", 32'(a_busy), 32'd1);
    chk("t5_addr_restart", 32'(a_mem_address), 32'd0);

    // ---- instance B: full-size sweep ----
    tick();
    reset_n_b = 1'b1;
    n = 0;
    @(negedge clk);
    while (b_busy === 1'b1 && n < 30000) begin
      n++;
      @(negedge clk);
    end
    chk("b_clear_cycles", 32'(n), 32'd25600);
    tick();

    // ---- test 2: byte-lane write then read back ----
    p0_write = 1'b1; p0_address = 15'h0010; p0_byteenable = 4'b0011; p0_writedata = 32'hCAFEF00D;
    @(negedge clk);
    chk("t2_wr", 32'({b_mem_chipselect, b_mem_write, b_mem_byteenable}), 32'h33);
    tick();
    idle_inputs();
    p0_read = 1'b1; p0_address = 15'h0010;
    @(negedge clk);
    chk("t2_wait", 32'(b_p0_waitrequest), 32'd0);
    tick();
    idle_inputs();
    @(negedge clk);
    chk("t2_rdv0", 32'(b_p0_readdatavalid), 32'd1);
    chk("t2_rdv1", 32'(b_p1_readdatavalid), 32'd0);
    chk("t2_data", b_p0_readdata, 32'h0000F00D);

    // ---- test 4: out-of-range read on p1 ----
    tick();
    p1_read = 1'b1; p1_address = 15'd25600;
    @(negedge clk);
    chk("t4_cs", 32'(b_mem_chipselect), 32'd0);
    chk("t4_wait", 32'(b_p1_waitrequest), 32'd0);
    tick();
    idle_inputs();
    @(negedge clk);
    chk("t4_rdv1", 32'(b_p1_readdatavalid), 32'd1);
    chk("t4_data", b_p1_readdata, 32'h0);
    chk("t4_flag", 32'(b_oor_flag), 32'd2);
    tick();
    oor_clear = 1'b1; p1_read = 1'b1; p1_address = 15'd25601;
    tick();
    oor_clear = 1'b0;
    idle_inputs();
    @(negedge clk);
    chk("t4_set_wins", 32'(b_oor_flag), 32'd2);
    tick();
    oor_clear = 1'b1;
    tick();
    oor_clear = 1'b0;
    @(negedge clk);
    chk("t4_cleared", 32'(b_oor_flag), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
